// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle for the digit-serial BCD adder.
// Optional subtract control is present only when BCD_SUB_EN is defined.
interface bcd_serial_adder_if #(
  parameter int NDIGITS = 4
);
  localparam int W = 4 * NDIGITS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef BCD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         invalid;

`ifdef BCD_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, cout, invalid);
  modport slave  (input start, a, b, sub, output busy, done, sum, cout, invalid);
`else
  modport master (output start, a, b, input busy, done, sum, cout, invalid);
  modport slave  (input start, a, b, output busy, done, sum, cout, invalid);
`endif
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder: one digit per clock, LSD first, then a one-cycle Done.
// Define BCD_SUB_EN to add A-B via nine's complement of B with an initial carry of 1.
module bcd_serial_adder #(
  parameter int NDIGITS = 4,
  parameter int CNTW    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  bcd_serial_adder_if.slave bus_io
);
  localparam int              W        = 4 * NDIGITS;
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NDIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            inv_q, inv_d;
  logic [CNTW-1:0] idx_q, idx_d;
  logic [3:0]      b_dig;
  logic [4:0]      dres;
`ifdef BCD_SUB_EN
  logic            sub_q, sub_d;
`endif

  // Returns {carry, digit}; digits above 9 still follow the T>9 rule, uncorrected.
  function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
    logic [4:0] t;
    t = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    if (t > 5'd9) digit_add = {1'b1, 4'(t - 5'd10)};
    else          digit_add = {1'b0, t[3:0]};
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] x);
    has_bad_digit = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9) has_bad_digit = 1'b1;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    inv_d   = inv_q;
    idx_d   = idx_q;
`ifdef BCD_SUB_EN
    sub_d   = sub_q;
    b_dig   = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
`else
    b_dig   = b_q[3:0];
`endif
    dres    = digit_add(a_q[3:0], b_dig, carry_q);

    case (state_q)
      S_IDLE: begin
        if (bus_io.start) begin
          a_d     = bus_io.a;
          b_d     = bus_io.b;
          sum_d   = '0;
          idx_d   = '0;
          inv_d   = has_bad_digit(bus_io.a) | has_bad_digit(bus_io.b);
`ifdef BCD_SUB_EN
          sub_d   = bus_io.sub;
          carry_d = bus_io.sub;
`else
          carry_d = 1'b0;
`endif
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        // Operand copies shift right so the current digit is always in bits [3:0].
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = dres[4];
        for (int i = 0; i < NDIGITS; i++) begin
          if (idx_q == CNTW'(i)) sum_d[4*i +: 4] = dres[3:0];
        end
        if (idx_q == LAST_IDX) begin
          cout_d  = dres[4];
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + CNTW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      inv_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      inv_q   <= inv_d;
      idx_q   <= idx_d;
    end
    a_q <= a_d;
    b_q <= b_d;
`ifdef BCD_SUB_EN
    sub_q <= sub_d;
`endif
  end

  assign bus_io.busy    = (state_q == S_ADD);
  assign bus_io.done    = (state_q == S_DONE);
  assign bus_io.sum     = sum_q;
  assign bus_io.cout    = cout_q;
  assign bus_io.invalid = inv_q;
endmodule
